// File: rtl/ha_array_reducer.sv
// Serial reducer for the four half-adder partial-product rows of the approximate 8x8 multiplier.
// Captures one row set, adds one weighted row per clock, then holds the 16-bit product until accepted.
module ha_array_reducer #(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [6:0]       ha_array_1_b,
    input  logic [6:0]       ha_array_2_b,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [8:0]       ha_array_1_t,
    input  logic [8:0]       ha_array_2_t,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] product,
    output logic             busy
);

    localparam int unsigned T_W   = 9;
    localparam int unsigned B_W   = 7;
    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [T_W-1:0]     r_t [ROWS];
    logic [B_W-1:0]     r_b [ROWS];
    logic [T_W-1:0]     w_in_t [ROWS];
    logic [B_W-1:0]     w_in_b [ROWS];
    logic [IDX_W-1:0]   r_idx;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_product;
    logic [ACC_W-1:0]   w_row;
    logic [ACC_W-1:0]   w_sum;
    logic               w_last;
    logic               w_capture;

    assign w_in_t[0] = ha_array_0_t;
    assign w_in_t[1] = ha_array_1_t;
    assign w_in_t[2] = ha_array_2_t;
    assign w_in_t[3] = ha_array_3_t;
    assign w_in_b[0] = ha_array_0_b;
    assign w_in_b[1] = ha_array_1_b;
    assign w_in_b[2] = ha_array_2_b;
    assign w_in_b[3] = ha_array_3_b;

    // Carry vector sits two bits above the sum vector; row k is further weighted by 4^k.
    assign w_row     = (ACC_W'(r_t[r_idx]) + (ACC_W'(r_b[r_idx]) << 2)) << {r_idx, 1'b0};
    assign w_sum     = r_acc + w_row;
    assign w_last    = (r_idx == IDX_W'(ROWS - 1));
    assign w_capture = (r_state == S_IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_nxt = S_ACC;
            S_ACC:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Row capture, serial accumulation and product hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(ROWS); k++) begin
                r_t[k] <= '0;
                r_b[k] <= '0;
            end
            r_idx     <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < int'(ROWS); k++) begin
                r_t[k] <= w_in_t[k];
                r_b[k] <= w_in_b[k];
            end
            r_idx <= '0;
            r_acc <= '0;
        end else if (r_state == S_ACC) begin
            r_acc <= w_sum;
            r_idx <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_product <= w_sum;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

endmodule

// File: tb/tb_ha_array_reducer.sv
// Self-checking bench for ha_array_reducer: directed cases plus randomized row sets against a bit-weight model.
module tb_ha_array_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  b [4];
    logic [8:0]  t [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ha_array_reducer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b[0]),
        .ha_array_1_b (b[1]),
        .ha_array_2_b (b[2]),
        .ha_array_3_b (b[3]),
        .ha_array_0_t (t[0]),
        .ha_array_1_t (t[1]),
        .ha_array_2_t (t[2]),
        .ha_array_3_t (t[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of 2^weight over every set bit, reduced modulo 2^16.
    function automatic logic [15:0] model();
        longint unsigned s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++) if (t[k][i]) s += longint'(1) << (i + 2 * k);
            for (int i = 0; i < 7; i++) if (b[k][i]) s += longint'(1) << (i + 2 + 2 * k);
        end
        return 16'(s % 65536);
    endfunction

    task automatic set_rows(input logic [8:0] tv, input logic [6:0] bv);
        for (int k = 0; k < 4; k++) begin
            t[k] = tv;
            b[k] = bv;
        end
    endtask

    task automatic randomize_rows();
        for (int k = 0; k < 4; k++) begin
            t[k] = 9'($urandom);
            b[k] = 7'($urandom);
        end
    endtask

    // Wait (bounded) for out_valid; returns number of negedges since the capture edge.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full transaction with the current rows; stall = cycles of out_ready low in DONE.
    task automatic do_txn(input string tag, input int stall);
        logic [15:0] exp;
        int n;
        exp = model();
        @(negedge clk);
        in_valid = 1'b1;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        randomize_rows();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(n);
        check({tag, "_latency"}, 32'(n), 32'd5);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (s == stall - 1) begin
                check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_stall_product"}, 32'(product), 32'(exp));
            end
        end
        check({tag, "_product"}, 32'(product), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        logic [15:0] exp1;
        logic [15:0] exp2;
        int n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_rows(9'h0, 7'h0);
        #12;
        rst = 1'b0;

        // Reset then idle with toggling inputs.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            randomize_rows();
            out_ready = 1'($urandom);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_product", 32'(product), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b0;

        // Single-bit weighting.
        set_rows(9'h0, 7'h0);
        t[0] = 9'h001;
        check("model_bit0", 32'(model()), 32'h0001);
        do_txn("t0_bit0", 0);
        set_rows(9'h0, 7'h0);
        b[3] = 7'h40;
        check("model_b3", 32'(model()), 32'h4000);
        do_txn("b3_bit6", 0);

        // Full tops and wrap-around.
        set_rows(9'h1FF, 7'h00);
        check("model_full_t", 32'(model()), 32'hA9AB);
        do_txn("full_t", 0);
        set_rows(9'h1FF, 7'h7F);
        check("model_wrap", 32'(model()), 32'h5257);
        do_txn("wrap", 0);

        // Backpressure: new data offered during ACC/DONE is ignored until IDLE.
        set_rows(9'h155, 7'h2A);
        exp1 = model();
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        set_rows(9'h0AA, 7'h55);
        exp2 = model();
        wait_valid(n);
        check("bp_latency", 32'(n), 32'd5);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            out_ready = (s == 3) ? 1'b0 : 1'b0;
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_valid_stable", 32'(out_valid), 32'd1);
            check("bp_product_stable", 32'(product), 32'(exp1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_pending_captured", 32'(busy), 32'd1);
        wait_valid(n);
        check("bp2_latency", 32'(n), 32'd5);
        check("bp2_product", 32'(product), 32'(exp2));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-ACC discards the partial sum and clears product.
        set_rows(9'h1FF, 7'h7F);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_product", 32'(product), 32'd0);
        set_rows(9'h0, 7'h0);
        t[1] = 9'h001;
        do_txn("after_rst", 0);
        check("after_rst_val", 32'(product), 32'h0004);

        // Randomized row sets with random stalls.
        for (int r = 0; r < 25; r++) begin
            randomize_rows();
            do_txn("rand", int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ha_array_reducer.md
Name: ha_array_reducer

Overview:
- Sequential consumer of the four half-adder partial-product rows emitted by the approximate 8x8 unsigned multiplier front end. Each row is a top/bottom vector pair.
- Captures one row set per valid/ready handshake and weights each row by bit position.
- Accumulates one row per clock into a 16-bit product, then presents it on a valid/ready output.
- Sits between the ha_array generator and the product consumer, replacing a wide combinational final adder with a 4-cycle serial reduction.

Parameters:
- ROWS, 4, number of ha_array row pairs; row k carries significance 2k.
- ACC_W, 16, accumulator/product width; the sum wraps modulo 2^ACC_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  row set presented.
- in_ready  output  1  block can capture a row set.
- ha_array_0_b … ha_array_3_b  input  7 each  bottom (carry) vectors, rows 0..3.
- ha_array_0_t … ha_array_3_t  input  9 each  top (sum) vectors, rows 0..3.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- product  output  16  reduced product.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, active-high): state=IDLE, row index=0, accumulator=0. Outputs: in_ready=1, out_valid=0, product=0, busy=0.
- Row weighting:
  - row_val(k) = Σ t[i]·2^(i+2k) for i=0..8, plus Σ b[i]·2^(i+2+2k) for i=0..6.
  - Max row_val before shift is 1019 (10 bits).
  - Additions are zero-extended to ACC_W and truncated modulo 2^ACC_W; there is no saturation and no overflow flag.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready at a clock edge, register all 8 vectors, clear the accumulator, set idx=0, and go to ACC.
  - ACC: in_ready=0. Each edge adds row_val(idx) to the accumulator and increments idx. On the edge that adds row ROWS-1, go to DONE. The registered inputs are used, so input-bus changes during ACC have no effect.
  - DONE: out_valid=1 and product=accumulator, held stable until out_ready=1. When out_valid&out_ready at an edge, go to IDLE; out_valid falls the next cycle.
- Latency:
  - The handshake edge is E0; rows are added on E1..E4.
  - out_valid is high in the cycle after E4, i.e. 5 cycles from the capture cycle.
  - Throughput is 1 set per 6 cycles when out_ready is held high.
- product updates only when entering DONE. It holds its last value in IDLE and ACC (0 after reset).
- in_valid high while not in IDLE is ignored; that data is not captured and not queued. The source must hold it until in_ready.
- out_ready low in DONE stalls indefinitely with product stable.
- out_ready high outside DONE has no effect.
- Reset asserted in any state, including mid-ACC or DONE with a pending product, immediately returns all state to reset values. The partial sum is discarded.
- No combinational path from in_valid/out_ready to any output: in_ready, out_valid and busy decode from the state register only.

Test Plan:
- Reset then idle: rst pulse, then inputs toggling with in_valid=0 → in_ready=1, out_valid=0, product=0x0000, busy=0 indefinitely.
- Single-bit weighting:
  - ha_array_0_t=9'h001, all else 0 → product=0x0001, out_valid 5 cycles after capture.
  - Separate transaction: ha_array_3_b=7'h40, all else 0 → product=0x4000.
- Full tops: all *_t=9'h1FF, all *_b=0 → product=0xA9AB (43435).
- Wrap-around: all *_t=9'h1FF and all *_b=7'h7F → 86615 mod 65536 = 0x5257.
- Handshake/backpressure:
  - out_ready=0 for 10 cycles in DONE → out_valid and product stay stable.
  - in_valid with new data during ACC/DONE is not captured and in_ready stays 0.
  - Raising out_ready → IDLE next cycle, then the pending set is captured.
- Reset mid-operation: assert rst on the 2nd ACC cycle → next cycle state IDLE, in_ready=1, out_valid=0, product=0x0000. A following clean transaction with ha_array_1_t=9'h001 gives product=0x0004.
